// File: rtl/alram_pkg.sv
// alram_pkg: shared constants and types for the two-port RAM arbiter slice.
//   WID   - RAM data width
//   AWID  - RAM address width
//   DEP   - RAM depth (1 << AWID)
//   owner_t     - requester id (0 = port 0, 1 = port 1)
//   arb_state_t - arbiter ownership state
package alram_pkg;

    localparam int WID  = 256;
    localparam int AWID = 5;
    localparam int DEP  = 1 << AWID;

    typedef logic owner_t;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

endpackage

// File: rtl/alram_rtag_pipe.sv
// alram_rtag_pipe: carries a (valid, owner id) tag alongside each issued RAM
// read so the returning data can be steered to the requester that issued it.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset; clears all in-flight tags
//   issue      in   a read was accepted at this edge
//   issue_id   in   owner of that read
//   m0_rvalid  out  returning read belongs to port 0 this cycle
//   m1_rvalid  out  returning read belongs to port 1 this cycle
module alram_rtag_pipe
    import alram_pkg::*;
#(
    parameter int RLAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   issue,
    input  owner_t issue_id,
    output logic   m0_rvalid,
    output logic   m1_rvalid
);

    // Stage 0 is loaded on the accepting edge (the same edge that registers
    // ram_ra), so stage RLAT lines up with the RAM's rdo.
    logic [RLAT:0] vld_q;
    logic [RLAT:0] id_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= {vld_q[RLAT-1:0], issue};
            id_q  <= {id_q[RLAT-1:0], issue_id};
        end
    end

    assign m0_rvalid = vld_q[RLAT] & ~id_q[RLAT];
    assign m1_rvalid = vld_q[RLAT] &  id_q[RLAT];

endmodule

// File: rtl/alram_arb2.sv
// alram_arb2: two-requester arbiter/sequencer driving one simple dual-port RAM.
// One transfer per cycle, round-robin between ports when idle, locked bursts
// capped at MAXBURST transfers, read data returned tagged to its requester.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   m0_* / m1_*                   requester ports (req, lock, we, addr, wdata
//                                 in; gnt, rvalid out)
//   rdata                         shared read data, zero unless an rvalid is high
//   ram_we, ram_wa, ram_wdi       registered RAM write port
//   ram_ra                        registered RAM read address
//   ram_rdo                       RAM read data
module alram_arb2
    import alram_pkg::*;
#(
    parameter int WID      = alram_pkg::WID,
    parameter int AWID     = alram_pkg::AWID,
    parameter int RLAT     = 1,
    parameter int MAXBURST = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_lock,
    input  logic            m0_we,
    input  logic [AWID-1:0] m0_addr,
    input  logic [WID-1:0]  m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    input  logic            m1_req,
    input  logic            m1_lock,
    input  logic            m1_we,
    input  logic [AWID-1:0] m1_addr,
    input  logic [WID-1:0]  m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [WID-1:0]  rdata,
    output logic            ram_we,
    output logic [AWID-1:0] ram_wa,
    output logic [WID-1:0]  ram_wdi,
    output logic [AWID-1:0] ram_ra,
    input  logic [WID-1:0]  ram_rdo
);

    localparam logic [7:0] CNT_LAST = 8'(MAXBURST - 1);

    arb_state_t state_q, state_d;
    owner_t     ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;

    logic            arb;
    logic            g0, g1;
    logic            acc;
    owner_t          acc_id;
    logic            acc_lock;
    logic            acc_we;
    logic [AWID-1:0] acc_addr;
    logic [WID-1:0]  acc_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // A locked owner that drops req gives up ownership in that same cycle,
    // so the port then arbitrates exactly as in IDLE and the waiting port can
    // be granted on the releasing edge.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        arb = (state_q == IDLE) ||
              (state_q == OWN0 && !m0_req) ||
              (state_q == OWN1 && !m1_req);
        if (!arb) begin
            g0 = (state_q == OWN0);
            g1 = (state_q == OWN1);
        end else if (m0_req && m1_req) begin
            g0 = ~ptr_q;
            g1 =  ptr_q;
        end else begin
            g0 = m0_req;
            g1 = m1_req;
        end
    end

    // Grants are forced low while reset is asserted so every output reads 0.
    assign m0_gnt = g0 & rst;
    assign m1_gnt = g1 & rst;

    assign acc       = g0 | g1;
    assign acc_id    = g1;
    assign acc_lock  = g1 ? m1_lock  : m0_lock;
    assign acc_we    = g1 ? m1_we    : m0_we;
    assign acc_addr  = g1 ? m1_addr  : m0_addr;
    assign acc_wdata = g1 ? m1_wdata : m0_wdata;

    // Pointer always points away from the last served port; hitting the
    // burst cap therefore hands priority to the other port automatically.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (arb) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        if (acc) begin
            ptr_d = ~acc_id;
            if (!acc_lock) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (arb) begin
                state_d = acc_id ? OWN1 : OWN0;
                cnt_d   = 8'd1;
            end else if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Write address/data and read address hold when not refreshed; only
    // ram_we is a one-cycle strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we  <= 1'b0;
            ram_wa  <= '0;
            ram_wdi <= '0;
            ram_ra  <= '0;
        end else begin
            ram_we <= acc & acc_we;
            if (acc && acc_we) begin
                ram_wa  <= acc_addr;
                ram_wdi <= acc_wdata;
            end
            if (acc && !acc_we) begin
                ram_ra <= acc_addr;
            end
        end
    end

    alram_rtag_pipe #(
        .RLAT(RLAT)
    ) u_rtag (
        .clk      (clk),
        .rst      (rst),
        .issue    (acc & ~acc_we),
        .issue_id (acc_id),
        .m0_rvalid(m0_rvalid),
        .m1_rvalid(m1_rvalid)
    );

    assign rdata = (m0_rvalid | m1_rvalid) ? ram_rdo : '0;

endmodule

// File: tb/tb_alram_arb2.sv
// tb_alram_arb2: directed self-checking bench for alram_arb2 with a simple
// behavioural RAM (1-cycle read latency) attached to the RAM-side ports.
module tb_alram_arb2;

    logic         clk;
    logic         rst;
    logic         m0_req, m0_lock, m0_we;
    logic [4:0]   m0_addr;
    logic [255:0] m0_wdata;
    logic         m0_gnt, m0_rvalid;
    logic         m1_req, m1_lock, m1_we;
    logic [4:0]   m1_addr;
    logic [255:0] m1_wdata;
    logic         m1_gnt, m1_rvalid;
    logic [255:0] rdata;
    logic         ram_we;
    logic [4:0]   ram_wa;
    logic [255:0] ram_wdi;
    logic [4:0]   ram_ra;
    logic [255:0] ram_rdo;

    int compared;
    int mismatched;

    alram_arb2 dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_lock  (m0_lock),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m1_req   (m1_req),
        .m1_lock  (m1_lock),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .rdata    (rdata),
        .ram_we   (ram_we),
        .ram_wa   (ram_wa),
        .ram_wdi  (ram_wdi),
        .ram_ra   (ram_ra),
        .ram_rdo  (ram_rdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: contents preset to 1000+addr while reset is low.
    logic [255:0] mem [32];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 256'(1000 + i);
            ram_rdo <= '0;
        end else begin
            if (ram_we) mem[ram_wa] <= ram_wdi;
            ram_rdo <= mem[ram_ra];
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] got,
                               input logic [255:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic lock,
                                 input logic we, input logic [4:0] addr,
                                 input logic [255:0] wdata);
        if (port == 0) begin
            m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkGrant(input string tag, input logic e0, input logic e1);
        #1;
        checkOutput({tag, " m0_gnt"}, 256'(m0_gnt), 256'(e0));
        checkOutput({tag, " m1_gnt"}, 256'(m1_gnt), 256'(e1));
    endtask

    task automatic applyReset();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 5'd0, '0);
        applyStimulus(1, 0, 0, 0, 5'd0, '0);
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 5'd0, '0);
        applyStimulus(1, 0, 0, 0, 5'd0, '0);
        step();
        step();
        checkOutput("reset ram_we", 256'(ram_we), 0);
        checkOutput("reset ram_ra", 256'(ram_ra), 0);
        checkOutput("reset rvalid", 256'({m0_rvalid, m1_rvalid}), 0);
        checkOutput("reset rdata", rdata, 0);
        rst = 1'b1;
        step();

        // m0 write 12 = 1230, then m0 read 12
        applyStimulus(0, 1, 0, 1, 5'd12, 256'd1230);
        checkGrant("t1 wr", 1, 0);
        step();
        checkOutput("t1 ram_we", 256'(ram_we), 1);
        checkOutput("t1 ram_wa", 256'(ram_wa), 12);
        checkOutput("t1 ram_wdi", ram_wdi, 1230);
        applyStimulus(0, 1, 0, 0, 5'd12, '0);
        checkGrant("t1 rd", 1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 5'd0, '0);
        checkOutput("t1 ram_we low", 256'(ram_we), 0);
        checkOutput("t1 ram_ra", 256'(ram_ra), 12);
        checkOutput("t1 rvalid early", 256'(m0_rvalid), 0);
        step();
        checkOutput("t1 m0_rvalid", 256'(m0_rvalid), 1);
        checkOutput("t1 m1_rvalid", 256'(m1_rvalid), 0);
        checkOutput("t1 rdata", rdata, 1230);
        step();
        checkOutput("t1 rvalid one cycle", 256'(m0_rvalid), 0);
        checkOutput("t1 rdata idle", rdata, 0);

        // Round-robin with both requesting, starting from reset
        applyReset();
        applyStimulus(0, 1, 0, 0, 5'd3, '0);
        applyStimulus(1, 1, 0, 1, 5'd4, 256'd77);
        for (int c = 0; c < 4; c++) begin
            checkGrant($sformatf("t2 c%0d", c), (c % 2) == 0, (c % 2) == 1);
            step();
            if (c == 1) begin
                checkOutput("t2 m0_rvalid", 256'(m0_rvalid), 1);
                checkOutput("t2 rdata", rdata, 1003);
            end
            if (c == 2) begin
                checkOutput("t2 m1 write wa", 256'(ram_wa), 4);
                checkOutput("t2 m1 write wdi", ram_wdi, 77);
            end
        end
        applyStimulus(0, 0, 0, 0, 5'd0, '0);
        applyStimulus(1, 0, 0, 0, 5'd0, '0);
        step();

        // m1 locked burst of 12 reads with m0 competing
        begin
            int a1;
            a1 = 0;
            for (int c = 0; c < 13; c++) begin
                applyStimulus(1, 1, (a1 < 11), 0, 5'(a1), '0);
                applyStimulus(0, (c >= 1 && c <= 8), 0, 0, 5'd20, '0);
                checkGrant($sformatf("t3 c%0d", c), c == 8, c != 8);
                if (m1_gnt) a1++;
                step();
                if (c == 1) begin
                    checkOutput("t3 m1_rvalid", 256'(m1_rvalid), 1);
                    checkOutput("t3 m1 rdata", rdata, 1000);
                end
                if (c == 9) begin
                    checkOutput("t3 m0_rvalid", 256'(m0_rvalid), 1);
                    checkOutput("t3 m0 rdata", rdata, 1020);
                end
            end
        end
        applyStimulus(0, 0, 0, 0, 5'd0, '0);
        applyStimulus(1, 0, 0, 0, 5'd0, '0);
        step();

        // m1 writes 13, m0 reads 13 the next cycle
        applyStimulus(1, 1, 0, 1, 5'd13, 256'd1330);
        checkGrant("t4 wr", 0, 1);
        step();
        applyStimulus(1, 0, 0, 0, 5'd0, '0);
        applyStimulus(0, 1, 0, 0, 5'd13, '0);
        checkGrant("t4 rd", 1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 5'd0, '0);
        step();
        checkOutput("t4 m0_rvalid", 256'(m0_rvalid), 1);
        checkOutput("t4 rdata", rdata, 1330);

        // Reset one cycle after a read is accepted
        step();
        applyStimulus(0, 1, 0, 0, 5'd12, '0);
        checkGrant("t5 rd", 1, 0);
        step();
        rst = 1'b0;
        applyStimulus(1, 1, 0, 0, 5'd1, '0);
        #1;
        checkOutput("t5 gnt in reset", 256'({m0_gnt, m1_gnt}), 0);
        checkOutput("t5 ram_ra", 256'(ram_ra), 0);
        checkOutput("t5 ram_we", 256'(ram_we), 0);
        checkOutput("t5 rdata", rdata, 0);
        for (int c = 0; c < 2; c++) begin
            step();
            checkOutput($sformatf("t5 rvalid r%0d", c), 256'({m0_rvalid, m1_rvalid}), 0);
        end
        applyStimulus(0, 0, 0, 0, 5'd0, '0);
        applyStimulus(1, 0, 0, 0, 5'd0, '0);
        rst = 1'b1;
        step();
        checkOutput("t5 rvalid post", 256'({m0_rvalid, m1_rvalid}), 0);
        applyStimulus(0, 1, 0, 0, 5'd2, '0);
        applyStimulus(1, 1, 0, 0, 5'd6, '0);
        checkGrant("t5 first", 1, 0);
        step();

        // Locked owner m0 drops req after 3 transfers
        applyStimulus(1, 0, 0, 0, 5'd0, '0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1, 1, 0, 5'(5 + c), '0);
            if (c > 0) applyStimulus(1, 1, 0, 0, 5'd9, '0);
            checkGrant($sformatf("t6 c%0d", c), 1, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 5'd0, '0);
        checkGrant("t6 release", 0, 1);
        step();
        applyStimulus(1, 0, 0, 0, 5'd0, '0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alram_arb2.md
Name: alram_arb2

Overview:
- Two-requester arbiter/sequencer in front of the 32x256 simple dual-port RAM (alram112x).
- Lets two datapath engines share one RAM instance; for example, the NTT core on port 0 and the sampler/hash unit on port 1.
- Serialises accesses to one operation per cycle, supports locked bursts with a bounded length, and returns read data tagged to the issuing requester.
- The RAM is instantiated outside this block; this block drives its ports.

Parameters:
- WID, 256, data width.
- AWID, 5, address width (depth 1<<AWID).
- RLAT, 1, RAM read latency in cycles, from ram_ra registered to ram_rdo valid; legal range 1..4.
- MAXBURST, 8, maximum consecutive transfers under lock before a forced release; legal range 2..255.

Ports:
- clk  in  1  single clock; also drives the RAM clkw/clkr.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  port-0 request; held, with its qualifiers stable, until m0_gnt.
- m0_lock  in  1  keep ownership after this transfer.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  AWID  address.
- m0_wdata  in  WID  write data.
- m0_gnt  out  1  transfer accepted at this rising edge when m0_req & m0_gnt.
- m0_rvalid  out  1  rdata belongs to port 0 this cycle.
- m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid: same as the m0_* signals, for port 1.
- rdata  out  WID  read data, shared by both ports; qualified by mX_rvalid.
- ram_we  out  1  to RAM we.
- ram_wa  out  AWID  to RAM wa.
- ram_wdi  out  WID  to RAM wdi.
- ram_ra  out  AWID  to RAM ra.
- ram_rdo  in  WID  from RAM rdo.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - State IDLE; round-robin pointer favours m0; burst counter 0.
  - Read-tag pipeline cleared, so in-flight reads are discarded and no rvalid follows.
- Grant:
  - Combinational from the req inputs and the registered state.
  - At most one of m0_gnt/m1_gnt is high in any cycle.
  - gnt never rises without the matching req.
- States:
  - IDLE:
    - A single request is granted.
    - If both request, the port not served last wins (round-robin). The pointer updates on every accepted transfer.
  - OWN0 / OWN1:
    - Only the owner can be granted; the other port's req is ignored.
    - IDLE -> OWNx on an accepted transfer from x with mX_lock=1.
    - OWNx -> IDLE when any of these occurs:
      - x is accepted with lock=0;
      - x deasserts req in a cycle (release takes effect that edge);
      - the burst counter reaches MAXBURST.
  - Burst counter:
    - Counts accepted transfers since entering OWNx; the entering transfer counts as 1.
    - Saturates at MAXBURST. On reaching it, the next state is IDLE and the pointer forces priority to the other port. If the other port is not requesting, the owner may be re-granted from IDLE.
    - Cleared on entering IDLE.
- Issue:
  - An accepted transfer at edge k drives the registered RAM signals during cycle k+1.
  - Write: ram_we=1, ram_wa=addr, ram_wdi=wdata. ram_we is 0 in all other cycles.
  - Read: ram_ra=addr; ram_ra holds its last value when no read is issued.
- Return:
  - For a read accepted at edge k, mX_rvalid is high for exactly one cycle, cycle k+1+RLAT.
  - rdata = ram_rdo in that cycle.
  - An owner tag travels in an RLAT+1-deep shift register (valid bit + id).
  - rdata is 0 when neither rvalid is high.
- Ordering:
  - Accesses reach the RAM in acceptance order, one per cycle.
  - A read of an address written by an earlier accepted transfer returns the new data. This holds because the write lands at edge k+2 and the read issues no earlier than k+2.
- Throughput: 1 transfer per cycle sustained; back-to-back reads pipeline without bubbles.
- Error handling: none. Address wrap is native (AWID bits), and there is no illegal address.

Decomposition:
- Package alram_pkg:
  - constants WID, AWID, DEP;
  - owner-id typedef (1 bit);
  - arbiter state enum {IDLE, OWN0, OWN1}.
- Sub-module alram_rtag_pipe: RLAT+1-deep valid/id shift register producing m0_rvalid/m1_rvalid, cleared by rst.
- Grant/FSM and RAM-side registers stay in the top.

Test Plan:
- m0 writes addr 12 = 1230; then m0 reads 12 → ram_we high one cycle with wa=12; m0_rvalid high at acceptance+2 (RLAT=1) with rdata=1230; m1_rvalid stays 0.
- m0 and m1 both request continuously, no lock: m0 reads addr 3, m1 writes addr 4 = 77 → grants alternate m0, m1, m0, …; after reset the first grant is m0.
- m1 holds lock=1 for 12 reads (addr 0..11) while m0 requests → m1 gets 8 consecutive grants (MAXBURST), then m0 is granted once, then m1 resumes.
- m1 writes addr 13 = 1330 and m0 reads addr 13 in the following cycle → m0 rdata = 1330, confirming write-before-read ordering.
- rst asserted low one cycle after a read is accepted → no rvalid appears, all outputs 0 immediately, and the first post-reset grant goes to m0.
- Locked owner drops req mid-burst after 3 transfers → the other port is granted on the same edge the owner's req is low.
